// File: rtl/apb_periph_xbar.sv
// 1-to-N APB interconnect: decodes upstream transfers against base/mask windows
// and replays them downstream. Define APB_XBAR_TIMEOUT_EN to abort hung ACCESS phases.
module apb_periph_xbar #(
    parameter int                             N_SLAVES       = 4,
    parameter int                             ADDR_WIDTH     = 32,
    parameter int                             DATA_WIDTH     = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_BASE       = {32'h1A10_3000, 32'h1A10_2000,
                                                                32'h1A10_1000, 32'h1A10_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_MASK       = {4{32'hFFFF_F000}},
    parameter logic [DATA_WIDTH-1:0]          ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int                             TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          slaver_PADDR,
    input  logic [DATA_WIDTH-1:0]          slaver_PWDATA,
    input  logic                           slaver_PWRITE,
    input  logic                           slaver_PSEL,
    input  logic                           slaver_PENABLE,
    output logic [DATA_WIDTH-1:0]          slaver_PRDATA,
    output logic                           slaver_PREADY,
    output logic                           slaver_PSLVERR,
    output logic [ADDR_WIDTH-1:0]          master_PADDR,
    output logic [DATA_WIDTH-1:0]          master_PWDATA,
    output logic                           master_PWRITE,
    output logic                           master_PENABLE,
    output logic [N_SLAVES-1:0]            master_PSEL,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] master_PRDATA,
    input  logic [N_SLAVES-1:0]            master_PREADY,
    input  logic [N_SLAVES-1:0]            master_PSLVERR,
    output logic                           timeout_o
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
    logic                    write_r, write_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [IDX_W:0]          dec_s;
    logic [N_SLAVES-1:0]     psel_r, psel_s;
    logic                    penable_r, penable_s;
    logic                    pready_r, pready_s;
    logic                    pslverr_r, pslverr_s;
    logic [DATA_WIDTH-1:0]   prdata_r, prdata_s;

`ifdef APB_XBAR_TIMEOUT_EN
    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             timeout_r, timeout_s;
`endif

    // Returns {hit, index}; scanning downward lets the lowest matching window win.
    function automatic logic [IDX_W:0] decode_addr(input logic [ADDR_WIDTH-1:0] addr);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            res = ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                  ? {1'b1, IDX_W'(i)} : res;
        end
        return res;
    endfunction

    function automatic logic [N_SLAVES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_SLAVES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        write_s   = write_r;
        idx_s     = idx_r;
        psel_s    = '0;
        penable_s = 1'b0;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
        dec_s     = decode_addr(slaver_PADDR);
`ifdef APB_XBAR_TIMEOUT_EN
        cnt_s     = cnt_r;
        timeout_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (slaver_PSEL && !slaver_PENABLE) begin
                    addr_s  = slaver_PADDR;
                    wdata_s = slaver_PWDATA;
                    write_s = slaver_PWRITE;
                    if (dec_s[IDX_W]) begin
                        idx_s   = dec_s[IDX_W-1:0];
                        psel_s  = onehot(dec_s[IDX_W-1:0]);
                        state_s = SETUP;
                    end else begin
                        pready_s  = 1'b1;
                        pslverr_s = 1'b1;
                        prdata_s  = slaver_PWRITE ? '0 : ERR_RDATA;
                        state_s   = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                psel_s    = onehot(idx_r);
                penable_s = 1'b1;
                state_s   = ACCESS;
`ifdef APB_XBAR_TIMEOUT_EN
                cnt_s     = '0;
`endif
            end
            ACCESS: begin
                if (master_PREADY[idx_r]) begin
                    pready_s  = 1'b1;
                    pslverr_s = master_PSLVERR[idx_r];
                    prdata_s  = write_r ? '0 : master_PRDATA[int'(idx_r)*DATA_WIDTH +: DATA_WIDTH];
                    state_s   = RESP;
                end
`ifdef APB_XBAR_TIMEOUT_EN
                // A ready in the limit cycle takes the branch above and completes normally.
                else if (cnt_r == TO_LIM) begin
                    pready_s  = 1'b1;
                    pslverr_s = 1'b1;
                    prdata_s  = write_r ? '0 : ERR_RDATA;
                    timeout_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    cnt_s     = cnt_r + CNT_W'(1);
                    psel_s    = onehot(idx_r);
                    penable_s = 1'b1;
                end
`else
                else begin
                    psel_s    = onehot(idx_r);
                    penable_s = 1'b1;
                end
`endif
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, captured transfer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            wdata_r   <= '0;
            write_r   <= 1'b0;
            idx_r     <= '0;
            psel_r    <= '0;
            penable_r <= 1'b0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            write_r   <= write_s;
            idx_r     <= idx_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
            prdata_r  <= prdata_s;
        end
    end

`ifdef APB_XBAR_TIMEOUT_EN
    // ACCESS wait counter and abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            timeout_r <= timeout_s;
        end
    end

    assign timeout_o = timeout_r;
`else
    assign timeout_o = 1'b0;
`endif

    assign master_PADDR   = addr_r;
    assign master_PWDATA  = wdata_r;
    assign master_PWRITE  = write_r;
    assign master_PSEL    = psel_r;
    assign master_PENABLE = penable_r;
    assign slaver_PREADY  = pready_r;
    assign slaver_PSLVERR = pslverr_r;
    assign slaver_PRDATA  = prdata_r;

endmodule

// File: tb/tb_apb_periph_xbar.sv
// Self-checking bench for apb_periph_xbar: directed scenarios plus randomized
// transfers compared against a cycle-timeline reference model.
`timescale 1ns/1ps
module tb_apb_periph_xbar;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam logic [DW-1:0] ERR_WORD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     slaver_PADDR = '0;
    logic [DW-1:0]     slaver_PWDATA = '0;
    logic              slaver_PWRITE = 1'b0;
    logic              slaver_PSEL = 1'b0;
    logic              slaver_PENABLE = 1'b0;
    logic [DW-1:0]     slaver_PRDATA;
    logic              slaver_PREADY;
    logic              slaver_PSLVERR;
    logic [AW-1:0]     master_PADDR;
    logic [DW-1:0]     master_PWDATA;
    logic              master_PWRITE;
    logic              master_PENABLE;
    logic [NS-1:0]     master_PSEL;
    logic [NS*DW-1:0]  master_PRDATA = '0;
    logic [NS-1:0]     master_PREADY = '0;
    logic [NS-1:0]     master_PSLVERR = '0;
    logic              timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    apb_periph_xbar #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .slaver_PADDR(slaver_PADDR), .slaver_PWDATA(slaver_PWDATA),
        .slaver_PWRITE(slaver_PWRITE), .slaver_PSEL(slaver_PSEL),
        .slaver_PENABLE(slaver_PENABLE), .slaver_PRDATA(slaver_PRDATA),
        .slaver_PREADY(slaver_PREADY), .slaver_PSLVERR(slaver_PSLVERR),
        .master_PADDR(master_PADDR), .master_PWDATA(master_PWDATA),
        .master_PWRITE(master_PWRITE), .master_PENABLE(master_PENABLE),
        .master_PSEL(master_PSEL), .master_PRDATA(master_PRDATA),
        .master_PREADY(master_PREADY), .master_PSLVERR(master_PSLVERR),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: slave i owns the 4 KiB page at 0x1A10_0000 + i*0x1000; first owner wins.
    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & 32'hFFFF_F000) == (32'h1A10_0000 + i * 32'h1000)) return i;
        end
        return -1;
    endfunction

    // Drive every slave with random noise; the selected one gets the chosen ready/data/err.
    task automatic drive_slaves(input int sel, input logic rdy, input logic [DW-1:0] d, input logic e);
        for (int j = 0; j < NS; j++) begin
            master_PRDATA[j*DW +: DW] = $urandom;
            master_PREADY[j]          = 1'($urandom_range(0, 1));
            master_PSLVERR[j]         = 1'($urandom_range(0, 1));
        end
        if (sel >= 0) begin
            master_PREADY[sel]          = rdy;
            master_PRDATA[sel*DW +: DW] = rdy ? d : DW'($urandom);
            master_PSLVERR[sel]         = rdy ? e : 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {master_PSEL, master_PENABLE, slaver_PREADY, slaver_PSLVERR, timeout_o, slaver_PRDATA}, '0);
        check_eq({tag, "_bus"}, {master_PADDR, master_PWDATA, master_PWRITE}, '0);
    endtask

    // Idle cycles; stale=1 holds PSEL with PENABLE high, which must never be captured.
    task automatic idle(input int n, input logic stale);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            slaver_PSEL    = stale;
            slaver_PENABLE = stale;
            drive_slaves(-1, 1'b0, '0, 1'b0);
            @(negedge clk);
            check_eq("idle_ctl", {master_PSEL, master_PENABLE, slaver_PREADY, slaver_PSLVERR, timeout_o, slaver_PRDATA}, '0);
        end
    endtask

    // One upstream transfer. waits<0 = slave never ready. stop_at>0 pulls reset after that cycle's check.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] sdata, input logic serr, input int stop_at);
        int idx;
        int resp_k;
        bit abort;
        logic [NS-1:0] exp_sel;
        logic exp_en, exp_rdy, exp_err, exp_to;
        logic [DW-1:0] exp_rd;
        idx   = ref_decode(addr);
        abort = 1'b0;
        if (idx < 0) begin
            resp_k = 1;
        end else begin
`ifdef APB_XBAR_TIMEOUT_EN
            abort  = (waits < 0) || (waits > TO);
            resp_k = abort ? 3 + TO : 3 + waits;
`else
            resp_k = (waits < 0) ? 1000000 : 3 + waits;
`endif
        end
        @(posedge clk); #1;
        slaver_PSEL    = 1'b1;
        slaver_PENABLE = 1'b0;
        slaver_PADDR   = addr;
        slaver_PWRITE  = wr;
        slaver_PWDATA  = wdata;
        drive_slaves(idx, 1'b0, '0, 1'b0);
        @(negedge clk);
        check_eq("setup_ctl", {master_PSEL, master_PENABLE, slaver_PREADY}, '0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            slaver_PENABLE = 1'b1;
            drive_slaves(idx, (waits >= 0) && (k == 2 + waits), sdata, serr);
            @(negedge clk);
            exp_sel = (idx >= 0 && k < resp_k) ? (NS'(1) << idx) : '0;
            exp_en  = (idx >= 0) && (k >= 2) && (k < resp_k);
            exp_rdy = (k == resp_k);
            exp_err = (k == resp_k) && ((idx < 0) || abort || serr);
            exp_to  = (k == resp_k) && abort;
            exp_rd  = (k == resp_k && !wr) ? ((idx < 0 || abort) ? ERR_WORD : sdata) : '0;
            check_eq("ctl", {master_PSEL, master_PENABLE, slaver_PREADY, slaver_PSLVERR, timeout_o},
                     {exp_sel, exp_en, exp_rdy, exp_err, exp_to});
            check_eq("prdata", slaver_PRDATA, exp_rd);
            if (idx >= 0 && k == 1) begin
                check_eq("paddr", master_PADDR, addr);
                check_eq("pwdata", {master_PWRITE, master_PWDATA}, {wr, wdata});
            end
            if (k == stop_at) begin
                #1 rst_n = 1'b0;
                #1 check_all_zero("async_rst");
                slaver_PSEL    = 1'b0;
                slaver_PENABLE = 1'b0;
                drive_slaves(-1, 1'b0, '0, 1'b0);
                @(posedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                break;
            end
            if (k == resp_k) break;
            if (k == 300) check_eq("xfer_bound", 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        int w;
        #2 check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        xfer(32'h1A10_1004, 1'b1, 32'hA5A5_0001, 0, 32'h0, 1'b0, 0);
        idle(1, 1'b0);
        xfer(32'h1A10_3010, 1'b0, 32'h0, 5, 32'h1234_5678, 1'b0, 0);
        idle(1, 1'b0);
        xfer(32'h2000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0, 0);
        xfer(32'h1A10_0008, 1'b1, 32'h0BAD_F00D, 0, 32'h0, 1'b1, 0);
        xfer(32'h1A10_2004, 1'b0, 32'h0, 1, 32'hCAFE_0002, 1'b0, 0);
        idle(3, 1'b1);
        xfer(32'h1A10_2000, 1'b0, 32'h0, -1, 32'h0, 1'b0, 100);
        idle(1, 1'b0);
        xfer(32'h1A10_1000, 1'b1, 32'h5555_AAAA, 3, 32'h0, 1'b0, 2);
        xfer(32'h1A10_0000, 1'b0, 32'h0, 0, 32'h7777_0000, 1'b0, 0);
        xfer(32'h1A10_2FFC, 1'b0, 32'h0, TO, 32'h0F0F_0F0F, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 4) a = 32'h3000_0000 | AW'($urandom_range(0, 32'hFF_FFFF));
            else a = 32'h1A10_0000 + AW'($urandom_range(0, NS - 1)) * 32'h1000 + AW'($urandom_range(0, 32'h3FF)) * 4;
            w = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            xfer(a, 1'($urandom_range(0, 1)), DW'($urandom), w, DW'($urandom), 1'($urandom_range(0, 1)), 0);
            idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
